// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, access-size enum and the data-memory base address.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  localparam logic [31:0] DM_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/dm_load_ext.sv
// Load data extractor: picks byte/halfword/word lane out of a raw memory word and extends it.
module dm_load_ext
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  mem_size_e   i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    w_byte = i_word[8*i_off +: 8];
    case (i_size)
      SZ_WORD: o_data = i_word;
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// MIPS MEM stage: word-organised data memory with byte-lane stores, extended loads,
// address-error detection and a committed-store counter.
module dm_stage
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic [31:0] dm_out,
  output logic        addr_err,
  output logic [31:0] store_cnt
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_store_cnt;

  logic [5:0]    w_op;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_in_range, w_misalign;
  logic          w_is_load, w_is_store, w_signed, w_we;
  mem_size_e     w_size;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane, w_rword, w_ext;
  logic          w_unused_ins;

  assign w_op         = ins_m[31:26];
  assign w_unused_ins = ^ins_m[25:0];
  assign w_off        = addr_m - BASE_ADDR;
  assign w_idx        = w_off[AW+1:2];
  assign w_in_range   = {1'b0, w_off} < LIMIT;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = SZ_WORD;
    case (w_op)
      OP_LW:  begin w_is_load = 1'b1; w_size = SZ_WORD; end
      OP_LH:  begin w_is_load = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
      OP_LHU: begin w_is_load = 1'b1; w_size = SZ_HALF; end
      OP_LB:  begin w_is_load = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
      OP_LBU: begin w_is_load = 1'b1; w_size = SZ_BYTE; end
      OP_SW:  begin w_is_store = 1'b1; w_size = SZ_WORD; end
      OP_SH:  begin w_is_store = 1'b1; w_size = SZ_HALF; end
      OP_SB:  begin w_is_store = 1'b1; w_size = SZ_BYTE; end
      default: ;
    endcase
  end

  always_comb begin
    case (w_size)
      SZ_WORD: w_misalign = |w_off[1:0];
      SZ_HALF: w_misalign = w_off[0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign addr_err = (w_is_load | w_is_store) & (~w_in_range | w_misalign);
  assign w_we     = w_is_store & ~addr_err;

  // Store data is replicated across lanes so the byte enables alone pick the destination.
  always_comb begin
    case (w_size)
      SZ_WORD: begin w_be = 4'b1111; w_wlane = wdata_m; end
      SZ_HALF: begin w_be = w_off[1] ? 4'b1100 : 4'b0011; w_wlane = {2{wdata_m[15:0]}}; end
      default: begin w_be = 4'b0001 << w_off[1:0]; w_wlane = {4{wdata_m[7:0]}}; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
      r_store_cnt <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      r_store_cnt <= r_store_cnt + 32'd1;
    end
  end

  assign w_rword = r_mem[w_idx];

  dm_load_ext u_load_ext (
    .i_word   (w_rword),
    .i_off    (w_off[1:0]),
    .i_size   (w_size),
    .i_signed (w_signed),
    .o_data   (w_ext)
  );

  assign dm_out    = (w_is_load & ~addr_err) ? w_ext : 32'd0;
  assign store_cnt = r_store_cnt;

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: directed plan followed by random traffic against a byte-addressed model.
module tb_dm_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_m, addr_m, wdata_m;
  logic [31:0] dm_out, store_cnt;
  logic        addr_err;

  dm_stage dut (
    .clk       (clk),
    .rst       (rst),
    .ins_m     (ins_m),
    .addr_m    (addr_m),
    .wdata_m   (wdata_m),
    .dm_out    (dm_out),
    .addr_err  (addr_err),
    .store_cnt (store_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] dm;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  mdl_mem [4096];
  logic [31:0] mdl_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".dm_out"},    dm_out,          e.dm);
      check({e.name, ".addr_err"},  {31'd0, addr_err}, {31'd0, e.err});
      check({e.name, ".store_cnt"}, store_cnt,       e.cnt);
    end
  end

  task automatic mdl_reset();
    for (int i = 0; i < 4096; i++) mdl_mem[i] = 8'h00;
    mdl_cnt = 32'd0;
  endtask

  // Drive one MEM cycle, queue the expected response, then advance the model past the edge.
  task automatic cyc(input string nm, input logic r, input logic [5:0] op,
                     input logic [31:0] a, input logic [31:0] wd, input bit push = 1'b1);
    logic [31:0] off, v;
    int          sz;
    bit          ld, st, sgn, err;
    exp_t        e;
    rst     = r;
    ins_m   = {op, 26'($urandom)};
    addr_m  = a;
    wdata_m = wd;
    off = a - DM_BASE_ADDR;
    ld  = op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    st  = op inside {OP_SW, OP_SH, OP_SB};
    sgn = op inside {OP_LH, OP_LB};
    sz  = (op inside {OP_LW, OP_SW}) ? 4 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2 :
          (op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : 0;
    err = (sz != 0) && ((off >= 32'd4096) || (off % sz != 0));
    v = 32'd0;
    if (ld && !err) begin
      for (int i = 0; i < sz; i++) v = v | (32'(mdl_mem[off + i]) << (8 * i));
      if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    end
    e.name = nm; e.dm = v; e.err = err; e.cnt = mdl_cnt;
    if (push) q.push_back(e);
    if (r) mdl_reset();
    else if (st && !err) begin
      for (int i = 0; i < sz; i++) mdl_mem[off + i] = wd[8*i +: 8];
      mdl_cnt = mdl_cnt + 32'd1;
    end
    @(posedge clk); #1;
  endtask

  localparam logic [5:0] OP_ADD = 6'h00;

  initial begin
    logic [5:0] ops [10];
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, OP_ADD, 6'h0F};
    mdl_reset();
    @(posedge clk); #1;
    cyc("rst", 1'b1, OP_ADD, 32'h0, 32'h0, 1'b0);

    cyc("t1_lw0",    1'b0, OP_LW,  32'h0,    32'h0);
    cyc("t1_lwFFC",  1'b0, OP_LW,  32'hFFC,  32'h0);
    cyc("t2_sw8",    1'b0, OP_SW,  32'h8,    32'h8899AABB);
    cyc("t2_lb8",    1'b0, OP_LB,  32'h8,    32'h0);
    cyc("t2_lbuB",   1'b0, OP_LBU, 32'hB,    32'h0);
    cyc("t2_lhA",    1'b0, OP_LH,  32'hA,    32'h0);
    cyc("t2_lhu8",   1'b0, OP_LHU, 32'h8,    32'h0);
    cyc("t3_sb11",   1'b0, OP_SB,  32'h11,   32'h12345677);
    cyc("t3_lw10a",  1'b0, OP_LW,  32'h10,   32'h0);
    cyc("t3_sh12",   1'b0, OP_SH,  32'h12,   32'h0000CAFE);
    cyc("t3_lw10b",  1'b0, OP_LW,  32'h10,   32'h0);
    cyc("t4_sw6",    1'b0, OP_SW,  32'h6,    32'hDEADBEEF);
    cyc("t4_lw4",    1'b0, OP_LW,  32'h4,    32'h0);
    cyc("t4_lh3",    1'b0, OP_LH,  32'h3,    32'h0);
    cyc("t4_sw1000", 1'b0, OP_SW,  32'h1000, 32'h11111111);
    cyc("t4_lw0",    1'b0, OP_LW,  32'h0,    32'h0);
    cyc("t5_sw20",   1'b0, OP_SW,  32'h20,   32'h1);
    cyc("t5_lw20",   1'b0, OP_LW,  32'h20,   32'h0);
    cyc("t5_add",    1'b0, OP_ADD, 32'h5,    32'hFFFFFFFF);
    cyc("t5_lw4",    1'b0, OP_LW,  32'h4,    32'h0);
    cyc("t6_rst_sw", 1'b1, OP_SW,  32'h40,   32'hFFFFFFFF);
    cyc("t6_lw40",   1'b0, OP_LW,  32'h40,   32'h0);
    cyc("t6_lw8",    1'b0, OP_LW,  32'h8,    32'h0);

    force dut.r_store_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_store_cnt;
    mdl_cnt = 32'hFFFF_FFFF;
    cyc("t6_wrap_sw", 1'b0, OP_SW, 32'h44,   32'h5A5A5A5A);
    cyc("t6_wrap_lw", 1'b0, OP_LW, 32'h44,   32'h0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int          pick;
      pick = $urandom_range(0, 15);
      if (pick == 0)      a = $urandom;
      else if (pick == 1) a = 32'hFF8 + 32'($urandom_range(0, 15));
      else                a = 32'($urandom_range(0, 63));
      cyc("rand", ($urandom_range(0, 99) == 0), ops[$urandom_range(0, 9)], a, $urandom);
    end

    rst = 1'b0; ins_m = '0; addr_m = '0; wdata_m = '0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d responses left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
